// File: rtl/fp_pkg.sv
// Shared definitions for the IEEE 754 single-precision operand path.
package fp_pkg;

    localparam int FP_BIAS  = 127;
    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;

    localparam logic [31:0]         FP_ZERO        = 32'h0000_0000;
    localparam logic [FP_EXP_W-1:0] FP_INT_MAX_EXP = 8'd158;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND,
        DONE
    } fp_state_t;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of a normalised magnitude (hidden bit dropped) into exp/mantissa.
module fp_round_rne
    import fp_pkg::*;
(
    input  logic [30:0]         mag,
    input  logic [FP_EXP_W-1:0] exp_in,
    output logic [FP_EXP_W-1:0] exp_out,
    output logic [FP_MAN_W-1:0] man_out,
    output logic                inexact
);

    logic [FP_MAN_W-1:0] man_trunc;
    logic                guard;
    logic                sticky;
    logic                round_up;
    logic [FP_MAN_W:0]   man_sum;

    assign man_trunc = mag[30:8];
    assign guard     = mag[7];
    assign sticky    = |mag[6:0];
    assign round_up  = guard & (sticky | man_trunc[0]);
    assign man_sum   = {1'b0, man_trunc} + {{FP_MAN_W{1'b0}}, round_up};

    // A carry out of the mantissa renormalises to 1.0 x 2^(exp+1).
    always_comb begin
        exp_out = exp_in;
        man_out = man_sum[FP_MAN_W-1:0];
        if (man_sum[FP_MAN_W]) begin
            exp_out = exp_in + 8'd1;
            man_out = '0;
        end
    end

    assign inexact = guard | sticky;

endmodule

// File: rtl/int_to_fp_encoder.sv
// Signed 32-bit integer to IEEE 754 single converter; serial normaliser, start/done handshake.
module int_to_fp_encoder
    import fp_pkg::*;
#(
    parameter int BIAS = FP_BIAS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] int_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        inexact
);

    localparam logic [FP_EXP_W-1:0] EXP_TOP = FP_EXP_W'(BIAS + 31);

    fp_state_t           state, state_nxt;
    logic                sign, sign_nxt;
    logic [31:0]         mag, mag_nxt;
    logic [4:0]          shcnt, shcnt_nxt;
    logic [31:0]         result_nxt;
    logic                inexact_nxt;

    logic [FP_EXP_W-1:0] norm_exp;
    logic [FP_EXP_W-1:0] rnd_exp;
    logic [FP_MAN_W-1:0] rnd_man;
    logic                rnd_inexact;

    assign norm_exp = EXP_TOP - {3'b000, shcnt};

    fp_round_rne u_round (
        .mag     (mag[30:0]),
        .exp_in  (norm_exp),
        .exp_out (rnd_exp),
        .man_out (rnd_man),
        .inexact (rnd_inexact)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sign    <= 1'b0;
            mag     <= '0;
            shcnt   <= '0;
            result  <= FP_ZERO;
            inexact <= 1'b0;
        end else begin
            state   <= state_nxt;
            sign    <= sign_nxt;
            mag     <= mag_nxt;
            shcnt   <= shcnt_nxt;
            result  <= result_nxt;
            inexact <= inexact_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        sign_nxt    = sign;
        mag_nxt     = mag;
        shcnt_nxt   = shcnt;
        result_nxt  = result;
        inexact_nxt = inexact;
        case (state)
            IDLE: begin
                if (start) begin
                    if (int_in == 32'd0) begin
                        result_nxt  = FP_ZERO;
                        inexact_nxt = 1'b0;
                        state_nxt   = DONE;
                    end else begin
                        // Negating 0x80000000 wraps to itself, which is the correct unsigned magnitude.
                        sign_nxt  = int_in[31];
                        mag_nxt   = int_in[31] ? (~int_in + 32'd1) : int_in;
                        shcnt_nxt = '0;
                        state_nxt = NORM;
                    end
                end
            end
            NORM: begin
                if (mag[31]) begin
                    state_nxt = ROUND;
                end else begin
                    mag_nxt   = {mag[30:0], 1'b0};
                    shcnt_nxt = shcnt + 5'd1;
                end
            end
            ROUND: begin
                result_nxt  = {sign, rnd_exp, rnd_man};
                inexact_nxt = rnd_inexact;
                state_nxt   = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule
